// File: rtl/tlb_maint_ctrl_pkg.sv
// Shared TLB definitions: maintenance op codes, INVTLB op encodings, entry layout.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
// Entry layout, MSB..LSB: VPPN[18:0] | PS[5:0] | G | ASID[9:0] | E | page pair (52 bits).
package tlb_pkg;

  localparam int ENTRY_W = 89;

  // Maintenance op codes; 5-7 are accepted and completed without effect.
  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  // INVTLB op field encodings.
  localparam logic [4:0] INV_ALL0        = 5'd0;
  localparam logic [4:0] INV_ALL1        = 5'd1;
  localparam logic [4:0] INV_G1          = 5'd2;
  localparam logic [4:0] INV_G0          = 5'd3;
  localparam logic [4:0] INV_G0_ASID     = 5'd4;
  localparam logic [4:0] INV_G0_ASID_VA  = 5'd5;
  localparam logic [4:0] INV_GASID_VA    = 5'd6;

  // Entry field offsets.
  localparam int VPPN_LSB = 70;
  localparam int VPPN_W   = 19;
  localparam int PS_LSB   = 64;
  localparam int PS_W     = 6;
  localparam int G_BIT    = 63;
  localparam int ASID_LSB = 53;
  localparam int ASID_W   = 10;
  localparam int E_BIT    = 52;

  // 4 MB page: only vppn[18:9] takes part in the VA compare.
  localparam logic [5:0] PS_4M = 6'd21;

  typedef enum logic [2:0] {
    M_LOOKUP,        // E && (G || ASID eq) && VA eq
    M_ALL,
    M_G1,
    M_G0,
    M_G0_ASID,
    M_G0_ASID_VA,
    M_GASID_VA,      // (G || ASID eq) && VA eq
    M_NONE
  } match_mode_t;

  function automatic match_mode_t inv_mode(input logic [4:0] op);
    match_mode_t m;
    case (op)
      INV_ALL0, INV_ALL1: m = M_ALL;
      INV_G1:             m = M_G1;
      INV_G0:             m = M_G0;
      INV_G0_ASID:        m = M_G0_ASID;
      INV_G0_ASID_VA:     m = M_G0_ASID_VA;
      INV_GASID_VA:       m = M_GASID_VA;
      default:            m = M_NONE;
    endcase
    return m;
  endfunction

  function automatic logic inv_op_legal(input logic [4:0] op);
    return op <= INV_GASID_VA;
  endfunction

endpackage

// File: rtl/tlb_maint_ctrl_if.sv
// Bundle between the EX/MEM requester, the maintenance controller and the TLB array ports.
// Latency: n/a (wires only).
// Backpressure: op_valid/op_ready handshake; op_ready is high only while the controller is idle.
// Ports: op request + operands + CSR snapshot (master->slave), array read/write ports,
// completion pulse with SRCH/RD/INV results and lookup_block (slave->master).
interface tlb_maint_ctrl_if #(
  parameter int IDX_W   = 4,
  parameter int ENTRY_W = 89
);
  logic               op_valid;
  logic               op_ready;
  logic [2:0]         op_code;
  logic [4:0]         inv_op;
  logic [9:0]         inv_asid;
  logic [18:0]        inv_vppn;
  logic [IDX_W-1:0]   csr_index;
  logic [9:0]         csr_asid;
  logic [18:0]        csr_vppn;
  logic [ENTRY_W-1:0] csr_wentry;

  logic               ent_rd_en;
  logic [IDX_W-1:0]   ent_rd_idx;
  logic [ENTRY_W-1:0] ent_rdata;
  logic               ent_we;
  logic [IDX_W-1:0]   ent_wr_idx;
  logic [ENTRY_W-1:0] ent_wdata;

  logic               done;
  logic               srch_hit;
  logic [IDX_W-1:0]   srch_idx;
  logic [ENTRY_W-1:0] rd_entry;
  logic               rd_valid;
  logic               exc_ine;
  logic               lookup_block;

  // Requester plus TLB array side.
  modport master (
    output op_valid, op_code, inv_op, inv_asid, inv_vppn,
           csr_index, csr_asid, csr_vppn, csr_wentry, ent_rdata,
    input  op_ready, ent_rd_en, ent_rd_idx, ent_we, ent_wr_idx, ent_wdata,
           done, srch_hit, srch_idx, rd_entry, rd_valid, exc_ine, lookup_block
  );

  // Maintenance controller side.
  modport slave (
    input  op_valid, op_code, inv_op, inv_asid, inv_vppn,
           csr_index, csr_asid, csr_vppn, csr_wentry, ent_rdata,
    output op_ready, ent_rd_en, ent_rd_idx, ent_we, ent_wr_idx, ent_wdata,
           done, srch_hit, srch_idx, rd_entry, rd_valid, exc_ine, lookup_block
  );

endinterface

// File: rtl/tlb_maint_ctrl_entry_match.sv
// Combinational match of one TLB entry against {vppn, asid, mode}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: ent_* entry fields, vppn/asid operands, mode selects the rule, hit is the result.
module tlb_entry_match
  import tlb_pkg::*;
(
  input  logic        ent_e,
  input  logic        ent_g,
  input  logic [9:0]  ent_asid,
  input  logic [5:0]  ent_ps,
  input  logic [18:0] ent_vppn,
  input  logic [18:0] vppn,
  input  logic [9:0]  asid,
  input  match_mode_t mode,
  output logic        hit
);

  logic asid_eq;
  logic va_eq;

  always_comb begin
    asid_eq = (ent_asid == asid);
    // Large pages ignore the low nine vppn bits.
    if (ent_ps == PS_4M) va_eq = (ent_vppn[18:9] == vppn[18:9]);
    else                 va_eq = (ent_vppn == vppn);

    hit = 1'b0;
    case (mode)
      M_LOOKUP:     hit = ent_e && (ent_g || asid_eq) && va_eq;
      M_ALL:        hit = 1'b1;
      M_G1:         hit = ent_g;
      M_G0:         hit = !ent_g;
      M_G0_ASID:    hit = !ent_g && asid_eq;
      M_G0_ASID_VA: hit = !ent_g && asid_eq && va_eq;
      M_GASID_VA:   hit = (ent_g || asid_eq) && va_eq;
      default:      hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB over dedicated array ports.
// Latency: RD 2, WR/FILL/illegal INV/unused 1, SRCH 2+hit_idx or TLBNUM+1, INV TLBNUM+1 cycles.
// Backpressure: one op in flight; op_ready low and lookup_block high until the done cycle.
// Ports: clk, aresetn (async active-low), bus (tlb_maint_ctrl_if.slave).
// Build option: define TLB_FILL_LFSR_EN to pick FILL slots from a free-running LFSR
// instead of the round-robin counter.
module tlb_maint_ctrl #(
  parameter int TLBNUM  = 16,
  parameter int IDX_W   = 4,
  parameter int ENTRY_W = 89
) (
  input  logic                clk,
  input  logic                aresetn,
  tlb_maint_ctrl_if.slave     bus
);
  import tlb_pkg::*;

  typedef enum logic [1:0] {IDLE, ACC, WALK, FIN} state_t;

  localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(TLBNUM);

  state_t             state, state_nxt;

  logic [2:0]         op_q;
  logic [4:0]         inv_op_q;
  logic [9:0]         inv_asid_q;
  logic [18:0]        inv_vppn_q;
  logic [IDX_W-1:0]   csr_index_q;
  logic [9:0]         csr_asid_q;
  logic [18:0]        csr_vppn_q;
  logic [ENTRY_W-1:0] wentry_q;

  // Walk cycle counter: read index = cnt, compare index = cnt-1.
  logic [IDX_W:0]     walk_cnt;
  logic [IDX_W-1:0]   cmp_idx;
  logic               cmp_vld;
  logic               walk_last;

  logic               accept;
  logic [IDX_W-1:0]   fill_idx;
  logic               fill_adv;

  match_mode_t        m_mode;
  logic [18:0]        m_vppn;
  logic [9:0]         m_asid;
  logic               m_hit;

  logic               rd_en_c, we_c, done_c, srch_hit_c, rd_valid_c, exc_ine_c;
  logic [IDX_W-1:0]   rd_idx_c, wr_idx_c, srch_idx_c;
  logic [ENTRY_W-1:0] wdata_c, rd_entry_c;

  assign accept    = bus.op_valid && (state == IDLE);
  assign cmp_vld   = (walk_cnt != '0);
  assign walk_last = (walk_cnt == LAST_CNT);
  assign cmp_idx   = walk_cnt[IDX_W-1:0] - IDX_W'(1);
  assign fill_adv  = (state == ACC) && (op_q == OP_FILL);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      op_q        <= '0;
      inv_op_q    <= '0;
      inv_asid_q  <= '0;
      inv_vppn_q  <= '0;
      csr_index_q <= '0;
      csr_asid_q  <= '0;
      csr_vppn_q  <= '0;
      wentry_q    <= '0;
    end else if (accept) begin
      op_q        <= bus.op_code;
      inv_op_q    <= bus.inv_op;
      inv_asid_q  <= bus.inv_asid;
      inv_vppn_q  <= bus.inv_vppn;
      csr_index_q <= bus.csr_index;
      csr_asid_q  <= bus.csr_asid;
      csr_vppn_q  <= bus.csr_vppn;
      wentry_q    <= bus.csr_wentry;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)           walk_cnt <= '0;
    else if (accept)        walk_cnt <= '0;
    else if (state == WALK) walk_cnt <= walk_cnt + (IDX_W+1)'(1);
  end

`ifdef TLB_FILL_LFSR_EN
  // Fibonacci LFSR x^16+x^15+x^13+x^4+1; free-running, the all-zero state is unreachable.
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
  end

  assign fill_idx = lfsr[IDX_W-1:0];
`else
  logic [IDX_W-1:0] fill_cnt;

  // TLBNUM is a power of two, so the natural wrap gives TLBNUM-1 -> 0.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)      fill_cnt <= '0;
    else if (fill_adv) fill_cnt <= fill_cnt + IDX_W'(1);
  end

  assign fill_idx = fill_cnt;
`endif

  // SRCH compares against the CSR snapshot; INV against its own operands.
  always_comb begin
    if (op_q == OP_SRCH) begin
      m_mode = M_LOOKUP;
      m_vppn = csr_vppn_q;
      m_asid = csr_asid_q;
    end else begin
      m_mode = inv_mode(inv_op_q);
      m_vppn = inv_vppn_q;
      m_asid = inv_asid_q;
    end
  end

  tlb_entry_match u_match (
    .ent_e    (bus.ent_rdata[E_BIT]),
    .ent_g    (bus.ent_rdata[G_BIT]),
    .ent_asid (bus.ent_rdata[ASID_LSB +: ASID_W]),
    .ent_ps   (bus.ent_rdata[PS_LSB +: PS_W]),
    .ent_vppn (bus.ent_rdata[VPPN_LSB +: VPPN_W]),
    .vppn     (m_vppn),
    .asid     (m_asid),
    .mode     (m_mode),
    .hit      (m_hit)
  );

  always_comb begin
    state_nxt  = state;
    rd_en_c    = 1'b0;
    rd_idx_c   = '0;
    we_c       = 1'b0;
    wr_idx_c   = '0;
    wdata_c    = '0;
    done_c     = 1'b0;
    srch_hit_c = 1'b0;
    srch_idx_c = '0;
    rd_entry_c = '0;
    rd_valid_c = 1'b0;
    exc_ine_c  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.op_valid) begin
          if (bus.op_code == OP_SRCH ||
              (bus.op_code == OP_INV && inv_op_legal(bus.inv_op)))
            state_nxt = WALK;
          else
            state_nxt = ACC;
        end
      end

      ACC: begin
        case (op_q)
          OP_RD: begin
            rd_en_c   = 1'b1;
            rd_idx_c  = csr_index_q;
            state_nxt = FIN;
          end
          OP_WR: begin
            we_c      = 1'b1;
            wr_idx_c  = csr_index_q;
            wdata_c   = wentry_q;
            done_c    = 1'b1;
            state_nxt = IDLE;
          end
          OP_FILL: begin
            we_c      = 1'b1;
            wr_idx_c  = fill_idx;
            wdata_c   = wentry_q;
            done_c    = 1'b1;
            state_nxt = IDLE;
          end
          OP_INV: begin
            // Only an illegal INVTLB op lands here; legal ones walk.
            done_c    = 1'b1;
            exc_ine_c = 1'b1;
            state_nxt = IDLE;
          end
          default: begin
            done_c    = 1'b1;
            state_nxt = IDLE;
          end
        endcase
      end

      FIN: begin
        done_c     = 1'b1;
        rd_entry_c = bus.ent_rdata;
        rd_valid_c = bus.ent_rdata[E_BIT];
        state_nxt  = IDLE;
      end

      WALK: begin
        // Read of index i+1 overlaps compare (and INV write) of index i.
        rd_en_c  = !walk_last;
        rd_idx_c = walk_cnt[IDX_W-1:0];
        if (cmp_vld) begin
          if (op_q == OP_SRCH) begin
            if (m_hit) begin
              done_c     = 1'b1;
              srch_hit_c = 1'b1;
              srch_idx_c = cmp_idx;
              state_nxt  = IDLE;
            end else if (walk_last) begin
              done_c    = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            if (m_hit) begin
              we_c         = 1'b1;
              wr_idx_c     = cmp_idx;
              wdata_c      = bus.ent_rdata;
              wdata_c[E_BIT] = 1'b0;
            end
            if (walk_last) begin
              done_c    = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.op_ready     = (state == IDLE);
  assign bus.lookup_block = (state != IDLE);
  assign bus.ent_rd_en    = rd_en_c;
  assign bus.ent_rd_idx   = rd_idx_c;
  assign bus.ent_we       = we_c;
  assign bus.ent_wr_idx   = wr_idx_c;
  assign bus.ent_wdata    = wdata_c;
  assign bus.done         = done_c;
  assign bus.srch_hit     = srch_hit_c;
  assign bus.srch_idx     = srch_idx_c;
  assign bus.rd_entry     = rd_entry_c;
  assign bus.rd_valid     = rd_valid_c;
  assign bus.exc_ine      = exc_ine_c;

endmodule
